// File: rtl/mem_pkg.sv
// Shared defaults and issue-stage command encoding for the memory request front-end.
package mem_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_ADDR   = 16;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_RD   = 2'd1,
    OP_WR   = 2'd2
  } op_e;

endpackage

// File: rtl/mem_rsp_fifo.sv
// Synchronous response FIFO: registered storage, head word presented while non-empty.
module mem_rsp_fifo #(
  parameter  int WIDTH = 12,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             not_empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_L = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign not_empty = (count_q != '0);
  assign count     = count_q;
  // Push on full is only legal alongside a pop; the read credit rule keeps it from happening otherwise.
  assign do_pop    = pop & not_empty;
  assign do_push   = push & ((count_q != FULL_L) | do_pop);
  assign head_data = not_empty ? mem_q[rptr_q] : '0;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + PTR_W'(1);
    if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && !do_push));
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Write/read request arbiter feeding mem_mod in acceptance order, with a credit-limited read response path.
module mem_req_ctrl
  import mem_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int MAX_ADDR   = DEF_MAX_ADDR,
  parameter  int RSP_DEPTH  = 4,
  localparam int ADDRSIZE   = $clog2(MAX_ADDR)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req_valid,
  output logic                  wr_req_ready,
  input  logic [ADDRSIZE-1:0]   wr_req_addr,
  input  logic [DATA_WIDTH-1:0] wr_req_data,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDRSIZE-1:0]   rd_req_addr,
  output logic                  rd_rsp_valid,
  input  logic                  rd_rsp_ready,
  output logic [DATA_WIDTH-1:0] rd_rsp_data,
  output logic [ADDRSIZE-1:0]   rd_rsp_addr,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [ADDRSIZE-1:0]   mem_rd_addr,
  output logic [ADDRSIZE-1:0]   mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  // Handshakes: a channel transfers when valid and ready are both high in the same cycle.
  // Readies are combinational functions of the valids; valids never look at readies.

  localparam int               CNT_W   = $clog2(RSP_DEPTH) + 1;
  localparam logic [CNT_W:0]   DEPTH_L = (CNT_W + 1)'(RSP_DEPTH);

  op_e                   op_q, op_d;
  logic [ADDRSIZE-1:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d, cap_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  cap_vld_q, last_wr_q, last_wr_d;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W:0]        occupancy;
  logic                  rd_ok, wr_acc, rd_acc, rsp_pop;
  logic [ADDRSIZE+DATA_WIDTH-1:0] rsp_head;

  // Every read still in issue or capture already owns a FIFO slot.
  assign occupancy = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(op_q == OP_RD) + (CNT_W + 1)'(cap_vld_q);
  assign rd_ok     = (occupancy < DEPTH_L);

  assign wr_req_ready = !rst & (!rd_req_valid | !rd_ok | !last_wr_q);
  assign rd_req_ready = !rst & rd_ok & (!wr_req_valid | last_wr_q);
  assign wr_acc       = wr_req_valid & wr_req_ready;
  assign rd_acc       = rd_req_valid & rd_req_ready;

  always_comb begin
    op_d      = OP_IDLE;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    last_wr_d = last_wr_q;
    if (wr_acc) begin
      op_d      = OP_WR;
      wr_addr_d = wr_req_addr;
      wr_data_d = wr_req_data;
      last_wr_d = 1'b1;
    end else if (rd_acc) begin
      op_d      = OP_RD;
      rd_addr_d = rd_req_addr;
      last_wr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= OP_IDLE;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      last_wr_q  <= 1'b0;
      cap_vld_q  <= 1'b0;
      cap_addr_q <= '0;
    end else begin
      op_q       <= op_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      last_wr_q  <= last_wr_d;
      cap_vld_q  <= (op_q == OP_RD);
      if (op_q == OP_RD) cap_addr_q <= rd_addr_q;
    end
  end

  assign mem_rd_en   = (op_q == OP_RD);
  assign mem_wr_en   = (op_q == OP_WR);
  assign mem_rd_addr = rd_addr_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = wr_data_q;

  assign rsp_pop = rd_rsp_valid & rd_rsp_ready;

  mem_rsp_fifo #(
    .WIDTH (ADDRSIZE + DATA_WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cap_vld_q),
    .push_data ({cap_addr_q, mem_rd_data}),
    .pop       (rsp_pop),
    .head_data (rsp_head),
    .not_empty (rd_rsp_valid),
    .count     (fifo_count)
  );

  assign rd_rsp_addr = rsp_head[ADDRSIZE+DATA_WIDTH-1:DATA_WIDTH];
  assign rd_rsp_data = rsp_head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: directed scenarios plus random traffic against an acceptance-order memory model.
module tb_mem_req_ctrl;

  localparam int DW    = 8;
  localparam int MA    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_req_valid, wr_req_ready, rd_req_valid, rd_req_ready;
  logic [AW-1:0] wr_req_addr, rd_req_addr, rd_rsp_addr, mem_rd_addr, mem_wr_addr;
  logic [DW-1:0] wr_req_data, rd_rsp_data, mem_wr_data;
  logic [DW-1:0] mem_rd_data = '0;
  logic          rd_rsp_valid, rd_rsp_ready, mem_rd_en, mem_wr_en;

  mem_req_ctrl #(.DATA_WIDTH(DW), .MAX_ADDR(MA), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
    .rd_rsp_data(rd_rsp_data), .rd_rsp_addr(rd_rsp_addr),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  // ---------------- clock and memory stand-in ----------------
  always #5 clk = ~clk;

  logic [DW-1:0] mem_array [MA];
  always @(posedge clk) begin
    if (mem_wr_en) mem_array[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= mem_array[mem_rd_addr];
  end

  // ---------------- reference model / scoreboard ----------------
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [DW-1:0]    shadow [MA];
  logic [AW+DW-1:0] exp_q [$];
  int               acc_q [$];
  logic             last_wr, prev_rst;
  logic             exp_wr_en, exp_rd_en;
  logic [AW-1:0]    exp_wr_addr, exp_rd_addr;
  logic [DW-1:0]    exp_wr_data;
  logic             wr_acc, rd_acc;
  int               rsp_cnt, first_rsp_cyc, last_rsp_cyc;
  logic [DW-1:0]    last_rsp_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check DUT outputs against the model, then record what transfers at the edge.
  task automatic step();
    logic exp_rd_ok, exp_wr_rdy, exp_rd_rdy, exp_vld;
    @(negedge clk);
    chk("mem_wr_en", mem_wr_en, exp_wr_en);
    chk("mem_rd_en", mem_rd_en, exp_rd_en);
    chk("both_en", mem_wr_en & mem_rd_en, 0);
    chk("mem_wr_addr", mem_wr_addr, exp_wr_addr);
    chk("mem_wr_data", mem_wr_data, exp_wr_data);
    chk("mem_rd_addr", mem_rd_addr, exp_rd_addr);

    exp_rd_ok  = (exp_q.size() < DEPTH);
    exp_wr_rdy = !rst && (!rd_req_valid || !exp_rd_ok || !last_wr);
    exp_rd_rdy = !rst && exp_rd_ok && (!wr_req_valid || last_wr);
    chk("wr_req_ready", wr_req_ready, exp_wr_rdy);
    chk("rd_req_ready", rd_req_ready, exp_rd_rdy);

    exp_vld = (exp_q.size() > 0) && (acc_q[0] + 3 <= cyc);
    chk("rd_rsp_valid", rd_rsp_valid, exp_vld);
    if (exp_vld) begin
      chk("rd_rsp_data", rd_rsp_data, exp_q[0][DW-1:0]);
      chk("rd_rsp_addr", rd_rsp_addr, exp_q[0][AW+DW-1:DW]);
    end
    if (rst && prev_rst) begin
      chk("rst_rsp_data", rd_rsp_data, 0);
      chk("rst_rsp_addr", rd_rsp_addr, 0);
    end

    if (rd_rsp_valid && rd_rsp_ready) begin
      if (rsp_cnt == 0) first_rsp_cyc = cyc;
      last_rsp_cyc  = cyc;
      last_rsp_data = rd_rsp_data;
      rsp_cnt++;
    end
    if (exp_vld && rd_rsp_ready) begin
      void'(exp_q.pop_front());
      void'(acc_q.pop_front());
    end

    wr_acc    = wr_req_valid & wr_req_ready;
    rd_acc    = rd_req_valid & rd_req_ready;
    exp_wr_en = wr_acc;
    exp_rd_en = rd_acc;
    if (wr_acc) begin
      shadow[wr_req_addr] = wr_req_data;
      exp_wr_addr = wr_req_addr;
      exp_wr_data = wr_req_data;
      last_wr = 1'b1;
    end
    if (rd_acc) begin
      exp_q.push_back({rd_req_addr, shadow[rd_req_addr]});
      acc_q.push_back(cyc);
      exp_rd_addr = rd_req_addr;
      last_wr = 1'b0;
    end
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      last_wr     = 1'b0;
      exp_wr_en   = 1'b0;
      exp_rd_en   = 1'b0;
      exp_wr_addr = '0;
      exp_wr_data = '0;
      exp_rd_addr = '0;
    end
    prev_rst = rst;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < max_cycles) begin
      step();
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int i, k, t_rd, got;
    for (int a = 0; a < MA; a++) begin
      mem_array[a] = '0;
      shadow[a]    = '0;
    end
    last_wr = 0; prev_rst = 1;
    exp_wr_en = 0; exp_rd_en = 0; exp_wr_addr = '0; exp_wr_data = '0; exp_rd_addr = '0;
    wr_acc = 0; rd_acc = 0; rsp_cnt = 0; first_rsp_cyc = 0; last_rsp_cyc = 0; last_rsp_data = '0;

    // Reset held with both request valids high.
    rst = 1; wr_req_valid = 1; rd_req_valid = 1;
    wr_req_addr = '0; wr_req_data = '0; rd_req_addr = '0; rd_rsp_ready = 1;
    repeat (3) step();
    rst = 0; wr_req_valid = 0; rd_req_valid = 0;
    step();

    // Write 0xA5 to 3, then read 3 the next cycle.
    wr_req_valid = 1; wr_req_addr = 4'd3; wr_req_data = 8'hA5;
    step();
    chk("t2_wr_acc", wr_acc, 1);
    wr_req_valid = 0; rd_req_valid = 1; rd_req_addr = 4'd3;
    t_rd = cyc;
    step();
    chk("t2_rd_acc", rd_acc, 1);
    rd_req_valid = 0;
    rsp_cnt = 0; got = 0;
    for (int n = 0; n < 10 && !got; n++) begin
      step();
      if (rsp_cnt > 0) got = 1;
    end
    chk("t2_rsp_seen", got, 1);
    chk("t2_rsp_latency", first_rsp_cyc - t_rd, 3);
    chk("t2_rsp_data", last_rsp_data, 8'hA5);

    // Both channels valid every cycle: grants must alternate.
    i = 0;
    for (int n = 0; n < 40 && i < 8; n++) begin
      logic prev_last;
      prev_last = last_wr;
      wr_req_valid = 1; wr_req_addr = AW'(i); wr_req_data = DW'(i);
      rd_req_valid = 1; rd_req_addr = '0;
      step();
      chk("t3_one_grant", 32'(wr_acc) + 32'(rd_acc), 1);
      chk("t3_alternate", wr_acc, !prev_last);
      if (wr_acc) i++;
    end
    chk("t3_writes_done", i, 8);
    wr_req_valid = 0; rd_req_valid = 0;
    drain(20);

    // Response backpressure: six reads, only four fit.
    rd_rsp_ready = 0; k = 0;
    for (int n = 0; n < 10; n++) begin
      rd_req_valid = (k < 6); rd_req_addr = AW'(2 + k);
      step();
      if (rd_acc) k++;
    end
    chk("t4_accepted", k, 4);
    chk("t4_rd_ready_low", rd_req_ready, 0);
    rd_rsp_ready = 1; rsp_cnt = 0;
    for (int n = 0; n < 40 && (k < 6 || exp_q.size() > 0); n++) begin
      rd_req_valid = (k < 6); rd_req_addr = AW'(2 + k);
      step();
      if (rd_acc) k++;
    end
    rd_req_valid = 0;
    chk("t4_all_accepted", k, 6);
    chk("t4_rsp_count", rsp_cnt, 6);

    // Back-to-back reads with the response side always ready.
    rsp_cnt = 0;
    for (int a = 0; a < 8; a++) begin
      rd_req_valid = 1; rd_req_addr = AW'(a);
      step();
      chk("t5_rd_acc", rd_acc, 1);
    end
    rd_req_valid = 0;
    for (int n = 0; n < 12 && rsp_cnt < 8; n++) step();
    chk("t5_rsp_count", rsp_cnt, 8);
    chk("t5_rsp_span", last_rsp_cyc - first_rsp_cyc, 7);

    // Reset with two reads in flight: they vanish.
    rsp_cnt = 0;
    rd_req_valid = 1; rd_req_addr = 4'd1;
    step();
    chk("t6_rd1_acc", rd_acc, 1);
    rd_req_addr = 4'd2;
    step();
    chk("t6_rd2_acc", rd_acc, 1);
    rd_req_valid = 0; rst = 1;
    step();
    rst = 0;
    repeat (6) step();
    chk("t6_no_rsp", rsp_cnt, 0);
    rd_req_valid = 1; rd_req_addr = 4'd5;
    step();
    chk("t6_rd5_acc", rd_acc, 1);
    rd_req_valid = 0;
    for (int n = 0; n < 10 && rsp_cnt == 0; n++) step();
    chk("t6_rsp_count", rsp_cnt, 1);
    chk("t6_rsp_data", last_rsp_data, 8'h05);

    // Random mixed traffic with random response backpressure.
    for (int n = 0; n < 400; n++) begin
      if (!wr_req_valid && $urandom_range(0, 1) == 1) begin
        wr_req_valid = 1;
        wr_req_addr  = AW'($urandom_range(0, MA - 1));
        wr_req_data  = DW'($urandom);
      end
      if (!rd_req_valid && $urandom_range(0, 1) == 1) begin
        rd_req_valid = 1;
        rd_req_addr  = AW'($urandom_range(0, MA - 1));
      end
      rd_rsp_ready = ($urandom_range(0, 3) != 0);
      step();
      if (wr_acc) wr_req_valid = 0;
      if (rd_acc) rd_req_valid = 0;
    end
    wr_req_valid = 0; rd_req_valid = 0; rd_rsp_ready = 1;
    drain(30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
